// File: rtl/sim_uart_tx.sv
// -----------------------------------------------------------------------------
// sim_uart_tx
//   Buffers bytes written to the sim-UART address in a small FIFO and sends
//   them out on the board's USB-UART TX pin as 8N1 (LSB first), so console
//   output appears on real hardware as well as in simulation.
//
//   Optional feature macro: SIM_UART_TX_PARITY_EN
//     defined   : an even-parity bit follows D7 (8E1, 11 bit times per frame)
//     undefined : plain 8N1 (10 bit times per frame)
//
// Parameters
//   CLK_FREQ   core clock in Hz
//   BAUD       line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (must be >= 2)
//   FIFO_DEPTH byte entries; power of 2, >= 2
//
// Ports
//   clk        in   core clock, all state on posedge
//   rstn       in   asynchronous active-low reset
//   char_in    in   byte to transmit
//   char_valid in   push strobe, one byte per high cycle
//   ovf_clr    in   synchronous clear of the overflow flag
//   tx         out  serial line, idle high, registered
//   busy       out  FIFO non-empty or frame in progress
//   fifo_count out  current FIFO occupancy, 0..FIFO_DEPTH
//   overflow   out  sticky: a byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module sim_uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    char_in,
    input  logic                          char_valid,
    input  logic                          ovf_clr,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CW           = PTR_W + 1;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]    CW_ZERO  = CW'(0);
    localparam logic [CW-1:0]    CW_ONE   = CW'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

`ifdef SIM_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             pop_s;
    logic             push_s;
    logic             drop_s;

`ifdef SIM_UART_TX_PARITY_EN
    // Even parity over the byte being sent.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // Transmit FSM: next state, bit timing, serial output and FIFO pop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (count_q != CW_ZERO) begin
                    pop_s   = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_START;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_LAST) begin
                    tx_d    = shreg_q[0];
                    idx_d   = 3'd0;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (idx_q == 3'd7) begin
`ifdef SIM_UART_TX_PARITY_EN
                        tx_d    = even_parity(shreg_q);
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shreg_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef SIM_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    tx_d    = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: a pop frees a slot in the same cycle, so a full FIFO
    // still accepts a byte on the IDLE->START cycle.
    always_comb begin
        push_s   = char_valid && ((count_q < CNT_FULL) || pop_s);
        drop_s   = char_valid && !push_s;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW_ONE;
            2'b01:   count_d = count_q - CW_ONE;
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear leaves the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FSM and FIFO control registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            idx_q    <= 3'd0;
            shreg_q  <= 8'h00;
            tx_q     <= 1'b1;
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CW_ZERO;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= char_in;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE) || (count_q != CW_ZERO);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule
